// File: rtl/ram_read_arbiter.sv
// Round-robin arbiter sharing one RAM read port among several requesters.
// Responses return tagged with the requester index, one or two cycles after grant.
module ram_read_arbiter #(
  parameter int NumPorts  = 4,
  parameter int PortBits  = 2,
  parameter int AddrWidth = 10,
  parameter int DataWidth = 8,
  parameter bit OutputReg = 1'b0
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NumPorts-1:0]           req_valid,
  input  logic [NumPorts*AddrWidth-1:0] req_addr,
  output logic [NumPorts-1:0]           req_ready,
  output logic [NumPorts-1:0]           resp_valid,
  output logic [PortBits-1:0]           resp_port,
  output logic [DataWidth-1:0]          resp_data,
  output logic                          ram_read_en,
  output logic [AddrWidth-1:0]          ram_read_addr,
  input  logic [DataWidth-1:0]          ram_read_data
);

  logic [PortBits-1:0] last_grant;
  logic                found;
  logic [PortBits-1:0] grant_idx;
  logic [PortBits:0]   cand;

  logic [NumPorts-1:0] s1_valid;
  logic [PortBits-1:0] s1_port;

  // Candidate index kept one bit wider so the wrap never overflows.
  always_comb begin
    found     = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int k = 1; k <= NumPorts; k++) begin
      cand = {1'b0, last_grant} + (PortBits+1)'(k);
      if (cand >= (PortBits+1)'(NumPorts)) begin
        cand = cand - (PortBits+1)'(NumPorts);
      end
      if (!found && req_valid[cand[PortBits-1:0]]) begin
        found     = 1'b1;
        grant_idx = cand[PortBits-1:0];
      end
    end
  end

  always_comb begin
    req_ready     = '0;
    ram_read_en   = found;
    ram_read_addr = '0;
    if (found) begin
      req_ready[grant_idx] = 1'b1;
      ram_read_addr = req_addr[int'(grant_idx)*AddrWidth +: AddrWidth];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant <= PortBits'(NumPorts-1);
      s1_valid   <= '0;
      s1_port    <= '0;
    end else begin
      if (found) begin
        last_grant <= grant_idx;
      end
      s1_valid <= req_ready;
      s1_port  <= found ? grant_idx : '0;
    end
  end

  generate
    if (OutputReg) begin : g_oreg
      logic [NumPorts-1:0]  s2_valid;
      logic [PortBits-1:0]  s2_port;
      logic [DataWidth-1:0] s2_data;

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          s2_valid <= '0;
          s2_port  <= '0;
          s2_data  <= '0;
        end else begin
          s2_valid <= s1_valid;
          s2_port  <= s1_port;
          if (|s1_valid) begin
            s2_data <= ram_read_data;
          end
        end
      end

      assign resp_valid = s2_valid;
      assign resp_port  = s2_port;
      assign resp_data  = s2_data;
    end else begin : g_direct
      assign resp_valid = s1_valid;
      assign resp_port  = s1_port;
      assign resp_data  = ram_read_data;
    end
  endgenerate

  a_ready_onehot: assert property (
    @(posedge clk) disable iff (reset) $onehot0(req_ready));
  a_resp_onehot: assert property (
    @(posedge clk) disable iff (reset) $onehot0(resp_valid));

endmodule

// File: tb/tb_ram_read_arbiter.sv
// Bench for ram_read_arbiter: two instances (direct and registered output)
// checked every cycle against a round-robin/latency model plus literal checks.
module tb_ram_read_arbiter;
  localparam int N  = 4;
  localparam int PB = 2;
  localparam int AW = 10;
  localparam int DW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            reset;
  logic [N-1:0]    req_valid;
  logic [N*AW-1:0] req_addr;

  logic [N-1:0]  rdy0, rdy1, rv0, rv1;
  logic [PB-1:0] rp0, rp1;
  logic [DW-1:0] rd0, rd1, rdata0, rdata1;
  logic          en0, en1;
  logic [AW-1:0] ra0, ra1;

  logic [DW-1:0] mem [1<<AW];

  always @(posedge clk) begin
    if (en0) rdata0 <= mem[ra0];
    if (en1) rdata1 <= mem[ra1];
  end

  ram_read_arbiter #(
    .NumPorts(N), .PortBits(PB), .AddrWidth(AW),
    .DataWidth(DW), .OutputReg(1'b0)
  ) dut0 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_addr(req_addr),
    .req_ready(rdy0), .resp_valid(rv0),
    .resp_port(rp0), .resp_data(rd0),
    .ram_read_en(en0), .ram_read_addr(ra0),
    .ram_read_data(rdata0)
  );

  ram_read_arbiter #(
    .NumPorts(N), .PortBits(PB), .AddrWidth(AW),
    .DataWidth(DW), .OutputReg(1'b1)
  ) dut1 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_addr(req_addr),
    .req_ready(rdy1), .resp_valid(rv1),
    .resp_port(rp1), .resp_data(rd1),
    .ram_read_en(en1), .ram_read_addr(ra1),
    .ram_read_data(rdata1)
  );

  int checks = 0;
  int errors = 0;

  // Model: last winner, current winner, and two response slots.
  int lg, g, p1, p2;
  bit v1, v2;
  logic [DW-1:0] d1, d2;

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic int arb();
    for (int k = 1; k <= N; k++) begin
      int p;
      p = (lg + k) % N;
      if (req_valid[p]) return p;
    end
    return -1;
  endfunction

  function automatic logic [AW-1:0] addr_of(input int p);
    return req_addr[p*AW +: AW];
  endfunction

  task automatic model_reset();
    lg = N - 1;
    v1 = 0; v2 = 0;
    p1 = 0; p2 = 0;
    d1 = '0; d2 = '0;
  endtask

  task automatic settle();
    logic [31:0] er, ea;
    @(negedge clk);
    g  = arb();
    er = (g >= 0) ? (32'd1 << g) : 32'd0;
    ea = (g >= 0) ? 32'(addr_of(g)) : 32'd0;
    chk("ready0", rdy0, er);
    chk("ready1", rdy1, er);
    chk("en0", en0, (g >= 0) ? 1 : 0);
    chk("en1", en1, (g >= 0) ? 1 : 0);
    chk("addr0", ra0, ea);
    chk("addr1", ra1, ea);
    chk("rvalid0", rv0, v1 ? (32'd1 << p1) : 32'd0);
    chk("rport0", rp0, v1 ? p1 : 0);
    if (v1) chk("rdata0", rd0, d1);
    chk("rvalid1", rv1, v2 ? (32'd1 << p2) : 32'd0);
    chk("rport1", rp1, v2 ? p2 : 0);
    chk("rdata1", rd1, d2);
  endtask

  task automatic tick();
    @(posedge clk);
    if (reset) begin
      model_reset();
    end else begin
      v2 = v1;
      p2 = p1;
      if (v1) d2 = d1;
      v1 = (g >= 0);
      p1 = (g >= 0) ? g : 0;
      if (g >= 0) begin
        d1 = mem[addr_of(g)];
        lg = g;
      end
    end
    #1;
  endtask

  task automatic drive(input logic [N-1:0] v, input int a0, input int a1,
                       input int a2, input int a3);
    req_valid = v;
    req_addr  = {AW'(a3), AW'(a2), AW'(a1), AW'(a0)};
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = 8'(i + 8'h10);
    rdata0 = '0;
    rdata1 = '0;
    reset = 1'b1;
    drive('0, 0, 0, 0, 0);
    model_reset();
    g = -1;
    @(posedge clk);
    #1;

    settle();
    chk("rst_rv", rv0, 0);
    chk("rst_port", rp0, 0);
    tick();
    reset = 1'b0;
    settle();
    chk("idle_en", en0, 0);
    chk("idle_addr", ra0, 0);
    tick();

    // Round robin with all four ports requesting.
    drive(4'b1111, 0, 1, 2, 3);
    for (int c = 0; c < 5; c++) begin
      settle();
      chk("rr_grant", rdy0, 32'd1 << (c % 4));
      if (c > 0) begin
        chk("rr_data", rd0, 32'(8'h10 + c - 1));
        chk("rr_port", rp0, c - 1);
      end
      tick();
    end

    // Wrap and skip: make port 3 the last winner, then ports 1 and 3.
    drive(4'b1000, 0, 0, 0, 3);
    settle();
    chk("wrap_pre", rdy0, 4'b1000);
    tick();
    drive(4'b1010, 0, 1, 0, 3);
    settle(); chk("wrap_a", rdy0, 4'b0010); tick();
    settle(); chk("wrap_b", rdy0, 4'b1000); tick();
    settle(); chk("wrap_c", rdy0, 4'b0010); tick();

    // Port 2 drops before it is ever granted.
    drive(4'b1000, 0, 0, 0, 3);
    settle(); tick();
    drive(4'b0101, 0, 0, 9, 0);
    settle(); chk("drop_g0", rdy0, 4'b0001); tick();
    drive(4'b0001, 0, 0, 0, 0);
    settle();
    chk("drop_g1", rdy0, 4'b0001);
    chk("drop_r0", rv0, 4'b0001);
    tick();
    drive('0, 0, 0, 0, 0);
    settle();
    chk("drop_r1", rv0, 4'b0001);
    chk("drop_r1b", rv1, 4'b0001);
    tick();
    settle();
    chk("drop_r2", rv0, 4'b0000);
    chk("drop_r2b", rv1, 4'b0001);
    tick();
    settle(); chk("drop_r3b", rv1, 4'b0000); tick();

    // Single port back-to-back reads of 5, 6, 7.
    for (int c = 0; c < 6; c++) begin
      if (c < 3) drive(4'b0010, 0, 5 + c, 0, 0);
      else drive('0, 0, 0, 0, 0);
      settle();
      if (c < 3) begin
        chk("sp_rdy0", rdy0, 4'b0010);
        chk("sp_rdy1", rdy1, 4'b0010);
      end
      if (c >= 1 && c <= 3) begin
        chk("sp_rv0", rv0, 4'b0010);
        chk("sp_rd0", rd0, 32'(8'h15 + c - 1));
        chk("sp_rp0", rp0, 1);
      end else begin
        chk("sp_rv0_idle", rv0, 0);
      end
      if (c >= 2 && c <= 4) begin
        chk("sp_rv1", rv1, 4'b0010);
        chk("sp_rd1", rd1, 32'(8'h15 + c - 2));
        chk("sp_rp1", rp1, 1);
      end else begin
        chk("sp_rv1_idle", rv1, 0);
      end
      if (c == 5) chk("sp_hold1", rd1, 8'h17);
      tick();
    end

    // Reset one cycle after port 2 is granted.
    drive(4'b0100, 0, 0, 3, 0);
    settle(); tick();
    drive('0, 0, 0, 0, 0);
    reset = 1'b1;
    model_reset();
    settle();
    chk("mid_rst_rv0", rv0, 0);
    chk("mid_rst_rp0", rp0, 0);
    chk("mid_rst_rv1", rv1, 0);
    tick();
    reset = 1'b0;
    settle(); tick();

    // Registered output: reset lands on the first response cycle.
    drive(4'b0010, 0, 5, 0, 0);
    settle(); tick();
    drive(4'b0010, 0, 6, 0, 0);
    settle(); tick();
    drive('0, 0, 0, 0, 0);
    reset = 1'b1;
    model_reset();
    settle();
    chk("or_rst_rv1", rv1, 0);
    chk("or_rst_rd1", rd1, 0);
    tick();
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      settle();
      chk("or_after_rv1", rv1, 0);
      chk("or_after_rv0", rv0, 0);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
